// File: rtl/instr_register_exec.sv
// ============================================================================
// Module      : instr_register_exec
// Description : 32-entry instruction register. A write is captured into a
//               one-stage execute register, its 64-bit result is computed
//               combinationally from that register, and the complete
//               instruction word is committed to the array on the next edge.
//               Reads are combinational, with bypass from the pending write.
//               Optional macro INSTR_REG_STATUS_EN adds a per-entry 2-bit
//               status (bit 0 = divide by zero, bit 1 = 32-bit overflow).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

typedef logic [4:0] address_t;

typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
} opcode_t;

typedef logic signed [31:0] operand_t;
typedef logic signed [63:0] operand_res;

typedef struct packed {
    opcode_t    opc;
    operand_t   op_a;
    operand_t   op_b;
    operand_res res;
} instruction_t;

module instr_register_exec #(
    parameter int     DEPTH    = 32,
    parameter longint DIV0_RES = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_en,
    input  address_t     write_pointer,
    input  opcode_t      opcode,
    input  operand_t     operand_a,
    input  operand_t     operand_b,
    input  address_t     read_pointer,
    output instruction_t instruction_word,
    output logic         entry_valid,
    output logic         exec_busy,
    output logic [5:0]   wr_count
`ifdef INSTR_REG_STATUS_EN
    ,
    output logic [1:0]   status
`endif
);

    localparam logic [5:0] WR_COUNT_MAX = 6'd63;

    // Execute-stage register
    opcode_t      exec_opc;
    operand_t     exec_a;
    operand_t     exec_b;
    address_t     exec_wp;

    // Result path
    operand_res   a_ext;
    operand_res   b_ext;
    operand_res   exec_res;
    instruction_t exec_word;

    // Storage
    instruction_t     mem [DEPTH];
    logic [DEPTH-1:0] valid;

`ifdef INSTR_REG_STATUS_EN
    logic [1:0]   exec_status;
    logic [1:0]   status_mem [DEPTH];
`endif

    // Capture a write request; the stage is busy for exactly the cycle after load_en
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exec_busy <= 1'b0;
            exec_opc  <= ZERO;
            exec_a    <= '0;
            exec_b    <= '0;
            exec_wp   <= '0;
        end else begin
            exec_busy <= load_en;
            if (load_en) begin
                exec_opc <= opcode;
                exec_a   <= operand_a;
                exec_b   <= operand_b;
                exec_wp  <= write_pointer;
            end
        end
    end

    // Operands widened to 64 bits so that products and quotients are exact
    assign a_ext = {{32{exec_a[31]}}, exec_a};
    assign b_ext = {{32{exec_b[31]}}, exec_b};

    // 64-bit signed result of the pending instruction
    always_comb begin
        exec_res = '0;
        case (exec_opc)
            ZERO:    exec_res = '0;
            PASSA:   exec_res = a_ext;
            PASSB:   exec_res = b_ext;
            ADD:     exec_res = a_ext + b_ext;
            SUB:     exec_res = a_ext - b_ext;
            MULT:    exec_res = a_ext * b_ext;
            DIV:     exec_res = (exec_b == '0) ? DIV0_RES : (a_ext / b_ext);
            MOD:     exec_res = (exec_b == '0) ? DIV0_RES : (a_ext % b_ext);
            default: exec_res = '0;
        endcase
    end

    assign exec_word = '{opc: exec_opc, op_a: exec_a, op_b: exec_b, res: exec_res};

`ifdef INSTR_REG_STATUS_EN
    // Divide by zero and signed 32-bit overflow flags of the pending instruction
    always_comb begin
        exec_status    = 2'b00;
        exec_status[0] = ((exec_opc == DIV) || (exec_opc == MOD)) && (exec_b == '0);
        exec_status[1] = ((exec_opc == ADD) || (exec_opc == SUB) || (exec_opc == MULT)) &&
                         (exec_res != {{32{exec_res[31]}}, exec_res[31:0]});
    end

    // Commit the pending status alongside its word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                status_mem[i] <= 2'b00;
            end
        end else if (exec_busy) begin
            status_mem[exec_wp] <= exec_status;
        end
    end
`endif

    // Commit the pending word into the array and mark the entry valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid <= '0;
        end else if (exec_busy) begin
            mem[exec_wp]   <= exec_word;
            valid[exec_wp] <= 1'b1;
        end
    end

    // Count committed writes, holding at the maximum
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count <= '0;
        end else if (exec_busy && (wr_count != WR_COUNT_MAX)) begin
            wr_count <= wr_count + 6'd1;
        end
    end

    // Combinational read; a pending write to the read address is forwarded
    always_comb begin
        instruction_word = mem[read_pointer];
        entry_valid      = valid[read_pointer];
`ifdef INSTR_REG_STATUS_EN
        status           = status_mem[read_pointer];
`endif
        if (exec_busy && (read_pointer == exec_wp)) begin
            instruction_word = exec_word;
            entry_valid      = 1'b1;
`ifdef INSTR_REG_STATUS_EN
            status           = exec_status;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_register_exec.sv
// ============================================================================
// Module      : tb_instr_register_exec
// Description : Self-checking bench for instr_register_exec. A behavioural
//               model (array of committed words plus one pending write)
//               predicts every output each cycle; directed sequences add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_register_exec;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load_en;
    address_t     write_pointer;
    opcode_t      opcode;
    operand_t     operand_a;
    operand_t     operand_b;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         entry_valid;
    logic         exec_busy;
    logic [5:0]   wr_count;
`ifdef INSTR_REG_STATUS_EN
    logic [1:0]   status;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    instr_register_exec dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .load_en          (load_en),
        .write_pointer    (write_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .entry_valid      (entry_valid),
        .exec_busy        (exec_busy),
        .wr_count         (wr_count)
`ifdef INSTR_REG_STATUS_EN
        ,
        .status           (status)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference rules
    // ------------------------------------------------------------------
    function automatic longint ref_res(input int opc, input int a, input int b);
        longint la = a;
        longint lb = b;
        case (opc)
            1:       return la;
            2:       return lb;
            3:       return la + lb;
            4:       return la - lb;
            5:       return la * lb;
            6:       return (b == 0) ? 64'sd0 : la / lb;
            7:       return (b == 0) ? 64'sd0 : la % lb;
            default: return 64'sd0;
        endcase
    endfunction

    function automatic logic [1:0] ref_status(input int opc, input int b, input longint r);
        longint lim = 64'sd2147483647;
        bit d0 = ((opc == 6) || (opc == 7)) && (b == 0);
        bit ov = (opc >= 3) && (opc <= 5) && ((r > lim) || (r < -lim - 1));
        return {ov, d0};
    endfunction

    // ------------------------------------------------------------------
    // Model state: committed entries plus at most one pending write
    // ------------------------------------------------------------------
    instruction_t m_word  [32];
    bit           m_valid [32];
    logic [1:0]   m_st    [32];
    bit           p_busy = 1'b0;
    instruction_t p_word;
    int           p_wp;
    logic [1:0]   p_st;
    int           m_cnt = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                m_word[i]  = '0;
                m_valid[i] = 1'b0;
                m_st[i]    = 2'b00;
            end
            p_busy = 1'b0;
            m_cnt  = 0;
        end else begin
            if (p_busy) begin
                m_word[p_wp]  = p_word;
                m_valid[p_wp] = 1'b1;
                m_st[p_wp]    = p_st;
                if (m_cnt < 63) m_cnt++;
            end
            p_busy = load_en;
            if (load_en) begin
                longint r;
                r      = ref_res(int'(opcode), operand_a, operand_b);
                p_word = '{opc: opcode, op_a: operand_a, op_b: operand_b, res: r};
                p_wp   = int'(write_pointer);
                p_st   = ref_status(int'(opcode), operand_b, r);
            end
        end
    end

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, on the inactive edge
    instruction_t e_word;
    logic         e_valid;
    logic [1:0]   e_st;
    always @(negedge clk) begin
        if (cmp_en) begin
            if (p_busy && (int'(read_pointer) == p_wp)) begin
                e_word  = p_word;
                e_valid = 1'b1;
                e_st    = p_st;
            end else begin
                e_word  = m_word[read_pointer];
                e_valid = m_valid[read_pointer];
                e_st    = m_st[read_pointer];
            end
            chk("cyc_word", instruction_word, e_word);
            chk("cyc_entry_valid", entry_valid, e_valid);
            chk("cyc_exec_busy", exec_busy, p_busy);
            chk("cyc_wr_count", wr_count, m_cnt);
`ifdef INSTR_REG_STATUS_EN
            chk("cyc_status", status, e_st);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_in(input bit le, input int wp, input int opc, input int a, input int b);
        load_en       = le;
        write_pointer = address_t'(wp);
        opcode        = opcode_t'(4'(opc));
        operand_a     = a;
        operand_b     = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int rp);
        read_pointer = address_t'(rp);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    function automatic int pick_operand();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return -1;
            2:       return int'(32'h8000_0000);
            3:       return int'($urandom_range(0, 40)) - 20;
            default: return int'($urandom);
        endcase
    endfunction

    initial begin
        reset_n = 1'b0;
        set_in(1'b0, 0, 0, 0, 0);
        read_pointer = '0;
        #1;

        // Reset state: every entry zero and invalid, no clock needed
        for (int i = 0; i < 32; i++) begin
            rd(i);
            chk("rst_word", instruction_word, '0);
            chk("rst_valid", entry_valid, 1'b0);
        end
        chk("rst_wr_count", wr_count, 6'd0);
        chk("rst_exec_busy", exec_busy, 1'b0);

        step();
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // ADD wp=3: -7 + 12 = 5, busy for one cycle
        set_in(1'b1, 3, 3, -7, 12);
        step();
        set_in(1'b0, 0, 0, 0, 0);
        rd(3);
        chk("add_busy_hi", exec_busy, 1'b1);
        chk("add_bypass_res", instruction_word.res, 64'sd5);
        step();
        chk("add_busy_lo", exec_busy, 1'b0);
        chk("add_res", instruction_word.res, 64'sd5);
        chk("add_valid", entry_valid, 1'b1);
        chk("add_wr_count", wr_count, 6'd1);

        // DIV / MOD / divide by zero
        set_in(1'b1, 5, 6, -15, 4);
        step();
        set_in(1'b1, 6, 7, -15, 4);
        step();
        set_in(1'b1, 7, 6, 9, 0);
        step();
        set_in(1'b0, 0, 0, 0, 0);
        step();
        rd(5);
        chk("div_res", instruction_word.res, -64'sd3);
`ifdef INSTR_REG_STATUS_EN
        chk("div_status", status, 2'b00);
`endif
        rd(6);
        chk("mod_res", instruction_word.res, -64'sd3);
`ifdef INSTR_REG_STATUS_EN
        chk("mod_status", status, 2'b00);
`endif
        rd(7);
        chk("div0_res", instruction_word.res, 64'sd0);
        chk("div0_valid", entry_valid, 1'b1);
`ifdef INSTR_REG_STATUS_EN
        chk("div0_status", status, 2'b01);
`endif

        // 20 back-to-back MULT writes, read through the bypass
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, i, 5, i - 10, i);
            step();
            rd(i);
            chk("mult_busy", exec_busy, 1'b1);
            chk("mult_bypass_res", instruction_word.res, longint'((i - 10) * i));
            chk("mult_bypass_valid", entry_valid, 1'b1);
        end
        set_in(1'b0, 0, 0, 0, 0);
        step();
        chk("mult_wr_count", wr_count, 6'd20);
        rd(19);
        chk("mult_res19", instruction_word.res, 64'sd171);

        // Same address twice: later write wins, both counted
        set_in(1'b1, 9, 2, 0, 11);
        step();
        set_in(1'b1, 9, 4, 2, 11);
        step();
        set_in(1'b0, 0, 0, 0, 0);
        step();
        rd(9);
        chk("ww_res", instruction_word.res, -64'sd9);
        chk("ww_opc", instruction_word.opc, SUB);
        chk("ww_wr_count", wr_count, 6'd22);

        // Reset between capture and commit discards the write
        set_in(1'b1, 4, 3, 1, 1);
        step();
        set_in(1'b0, 0, 0, 0, 0);
        pulse_reset();
        rd(4);
        chk("rstmid_valid", entry_valid, 1'b0);
        chk("rstmid_busy", exec_busy, 1'b0);
        step();
        chk("rstmid_word", instruction_word, '0);
        chk("rstmid_valid2", entry_valid, 1'b0);
        chk("rstmid_wr_count", wr_count, 6'd0);

        // Randomized traffic, long enough after the mid-run reset to saturate wr_count
        for (int c = 0; c < 400; c++) begin
            int wp;
            int opc;
            int b;
            wp  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 31));
            opc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
            b   = ($urandom_range(0, 5) == 0) ? 0 : pick_operand();
            set_in($urandom_range(0, 3) != 0, wp, opc, pick_operand(), b);
            if (p_busy && ($urandom_range(0, 1) == 1)) begin
                read_pointer = address_t'(p_wp);
            end else begin
                read_pointer = address_t'($urandom_range(0, 31));
            end
            if (c == 150) begin
                pulse_reset();
            end
            step();
        end
        set_in(1'b0, 0, 0, 0, 0);
        step();
        chk("rand_wr_count_sat", wr_count, 6'd63);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
